// File: rtl/nco_pkg.sv
// NCO shared definitions: control-word field layout and wave-select codes.
package nco_pkg;

    localparam int CW_WIDTH = 32;
    localparam int WAVE_MSB = 31;
    localparam int WAVE_LSB = 30;
    localparam int MODE_BIT = 29;
    localparam int INC_MSB  = 28;
    localparam int INC_LSB  = 0;
    localparam int INC_WIDTH = INC_MSB - INC_LSB + 1;

    typedef logic [WAVE_MSB-WAVE_LSB:0] wave_sel_t;

    localparam wave_sel_t WAVE_SAW    = 2'b00;
    localparam wave_sel_t WAVE_SQUARE = 2'b01;
    localparam wave_sel_t WAVE_TRI    = 2'b10;
    localparam wave_sel_t WAVE_RSVD   = 2'b11;

endpackage

// File: rtl/nco_phase_accumulator_if.sv
// Control/sample bundle between an NCO voice and its host.
interface nco_phase_accumulator_if #(
    parameter int OUT_WIDTH = 12
);
    import nco_pkg::*;

    logic [CW_WIDTH-1:0]  i_control_word;
    logic                 i_hard_sync;
    logic [OUT_WIDTH-1:0] o_wave;
    logic                 o_wave_valid;
    logic                 o_wrap;
    logic                 o_pending;

    modport master (
        output i_control_word,
        output i_hard_sync,
        input  o_wave,
        input  o_wave_valid,
        input  o_wrap,
        input  o_pending
    );

    modport slave (
        input  i_control_word,
        input  i_hard_sync,
        output o_wave,
        output o_wave_valid,
        output o_wrap,
        output o_pending
    );

endinterface

// File: rtl/nco_waveshaper.sv
// Registered phase-to-sample mapping; takes the top OUT_WIDTH+1 phase bits.
module nco_waveshaper
    import nco_pkg::*;
#(
    parameter int OUT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OUT_WIDTH:0]   phase,
    input  wave_sel_t            sel,
    input  logic                 strobe,
    output logic [OUT_WIDTH-1:0] wave,
    output logic                 valid
);

    logic                 msb;
    logic [OUT_WIDTH-1:0] tri_t;
    logic [OUT_WIDTH-1:0] shape;

    assign msb   = phase[OUT_WIDTH];
    assign tri_t = phase[OUT_WIDTH-1:0];

    always_comb begin
        shape = '0;
        unique case (sel)
            WAVE_SAW:    shape = phase[OUT_WIDTH -: OUT_WIDTH];
            WAVE_SQUARE: shape = msb ? '0 : '1;
            WAVE_TRI:    shape = msb ? ~tri_t : tri_t;
            WAVE_RSVD:   shape = {1'b1, {(OUT_WIDTH-1){1'b0}}};
            default:     shape = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wave  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= strobe;
            if (strobe) begin
                wave <= shape;
            end
        end
    end

endmodule

// File: rtl/nco_phase_accumulator.sv
// One NCO voice: prescaled phase accumulator with immediate or wrap-aligned
module nco_phase_accumulator
    import nco_pkg::*;
#(
    parameter int PHASE_WIDTH = 32,
    parameter int OUT_WIDTH   = 12,
    parameter int DIVIDE      = 1
) (
    input logic                    i_clock,
    input logic                    i_reset,
    nco_phase_accumulator_if.slave bus
);

    localparam int PS_W = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;

    logic [PS_W-1:0]        presc;
    logic                   tick;
    logic [PHASE_WIDTH-1:0] phase;
    logic [PHASE_WIDTH:0]   sum;
    logic                   carry;
    logic [INC_WIDTH-1:0]   inc;
    wave_sel_t              sel;
    logic [CW_WIDTH-1:0]    hist;
    logic [INC_WIDTH-1:0]   pend_inc;
    wave_sel_t              pend_sel;
    logic                   pending;
    logic                   apply_imm;
    logic                   apply;
    logic                   change;
    logic                   mode;
    logic                   hs;
    logic                   wrap;
    logic                   strobe;

    assign hs     = bus.i_hard_sync;
    assign tick   = (presc == PS_W'(DIVIDE - 1));
    assign sum    = {1'b0, phase} + (PHASE_WIDTH + 1)'(inc);
    assign carry  = sum[PHASE_WIDTH];
    assign change = (bus.i_control_word != hist);
    assign mode   = bus.i_control_word[MODE_BIT];

    // a deferred word lands on a natural carry or a hard sync
    assign apply = apply_imm | (pending & (hs | (tick & carry)));

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            presc     <= '0;
            phase     <= '0;
            inc       <= '0;
            sel       <= WAVE_SAW;
            hist      <= '0;
            pend_inc  <= '0;
            pend_sel  <= WAVE_SAW;
            pending   <= 1'b0;
            apply_imm <= 1'b0;
            wrap      <= 1'b0;
            strobe    <= 1'b0;
        end else begin
            presc  <= tick ? '0 : presc + 1'b1;
            wrap   <= tick & ~hs & carry;
            strobe <= tick & ~hs;
            if (hs) begin
                phase <= '0;
            end else if (tick) begin
                phase <= sum[PHASE_WIDTH-1:0];
            end
            if (apply) begin
                sel     <= pend_sel;
                inc     <= pend_inc;
                pending <= 1'b0;
            end
            // a same-edge change re-arms pending after the old word is applied
            apply_imm <= change & ~mode;
            if (change) begin
                hist     <= bus.i_control_word;
                pend_sel <= bus.i_control_word[WAVE_MSB:WAVE_LSB];
                pend_inc <= bus.i_control_word[INC_MSB:INC_LSB];
                pending  <= mode;
            end
        end
    end

    nco_waveshaper #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_shaper (
        .clk    (i_clock),
        .rst    (i_reset),
        .phase  (phase[PHASE_WIDTH-1 -: OUT_WIDTH+1]),
        .sel    (sel),
        .strobe (strobe),
        .wave   (bus.o_wave),
        .valid  (bus.o_wave_valid)
    );

    assign bus.o_wrap    = wrap;
    assign bus.o_pending = pending;

endmodule
